audio_window_averager: RTL and testbench
========================================

AUDIO_WINDOW_AVERAGER -- requirements
Module: audio_window_averager

Interface
REQ-001 Parameter DATA_W, default 12: mic sample width in bits.
REQ-002 Parameter LOG2_N, default 5: log2 of the averaging window length; N = 2^LOG2_N; legal range 1..10.
REQ-003 Parameter DECIM, default 10: Clk_20khz cycles per sample tick; legal range >= 2.
REQ-004 Parameter MODE, default 0: 0 = block (tumbling) average, 1 = moving (boxcar) average.
REQ-005 Clk_20khz  input  1  system clock; all state is updated on its rising edge only.
REQ-006 Rst  input  1  reset; asynchronous, active-high.
REQ-007 clr  input  1  synchronous window restart, active-high.
REQ-008 mic_in  input  DATA_W  unsigned mic sample.
REQ-009 thresh  input  DATA_W  unsigned level threshold.
REQ-010 avg_out  output  DATA_W  latest window average, registered.
REQ-011 avg_valid  output  1  one-cycle pulse marking an avg_out update.
REQ-012 over_thresh  output  1  registered flag: avg_out >= thresh, evaluated at each avg_out update.

Function
REQ-013 Decimator: counter runs 0..DECIM-1 and wraps; a tick occurs on the edge where counter == DECIM-1; the first tick is the DECIM-th rising edge after Rst deasserts.
REQ-014 mic_in is sampled only on tick edges; it is ignored on all other edges.
REQ-015 Accumulator width is DATA_W+LOG2_N; it never overflows or wraps for any input sequence.
REQ-016 Block mode, per tick: acc += mic_in and cnt++.
REQ-017 Block mode, on the tick that captures the N-th sample: avg_out <= (acc+mic_in) >> LOG2_N; acc <= 0; cnt <= 0; avg_valid = 1.
REQ-018 Moving mode uses an N-deep ring buffer, write pointer wp (wraps N-1 -> 0) and fill flag full.
REQ-019 Moving mode, per tick: sum <= sum + mic_in - (full ? buf[wp] : 0); buf[wp] <= mic_in; wp++.
REQ-020 Moving mode: full sets on the tick writing the N-th sample and stays set; ring-buffer contents need no reset.
REQ-021 Moving mode, on every tick where full is set or is being set on that tick: avg_out <= new_sum >> LOG2_N; avg_valid = 1.
REQ-022 Division is truncating (floor) right shift; no rounding.
REQ-023 avg_valid is high exactly one Clk_20khz cycle per update, coincident with the new avg_out value.
REQ-024 over_thresh is updated on the same edge as avg_out, using the new average; it holds otherwise.
REQ-025 clr restarts the window: decimator, acc/sum, cnt, wp and full go to 0; avg_out and over_thresh hold; avg_valid = 0.
REQ-026 clr has priority over a coincident tick: that sample is discarded.
REQ-027 Changes to thresh between updates have no effect until the next avg_valid.

Reset
REQ-028 Rst clears asynchronously: decimator, acc, sum, cnt, wp and full = 0; avg_out = 0; avg_valid = 0; over_thresh = 0.
REQ-029 Rst mid-window discards the partial window; the first tick after release follows REQ-013.
REQ-030 The ring buffer is not reset; correctness after reset relies on full = 0 (REQ-019).

Verification
Benches use DATA_W=12, LOG2_N=3 (N=8), DECIM=10.
REQ-031 Block mode, mic_in=100 constant -> first avg_valid on the 80th edge after reset release; avg_out=100; next avg_valid on edge 160.
REQ-032 Block mode, samples 0,1,..,7 -> avg_out=3 (28>>3); all samples 4095 -> avg_out=4095, no wrap.
REQ-033 Moving mode, eight samples of 800, then 0s -> avg_valid at ticks 8,9,10,...; avg_out = 800,700,600,500,400,300,200,100,0.
REQ-034 clr pulsed on the edge of the 4th tick in block mode -> that sample is dropped, no avg_valid, avg_out holds; next avg_valid 8 ticks later, containing only post-clr samples.
REQ-035 thresh=500, block mode, windows averaging 499 then 500 -> over_thresh = 0, then 1, each on the avg_valid edge.
REQ-036 Rst asserted mid-window in moving mode, with the buffer previously filled with 4095 -> all outputs 0 at once; refill with 8x10 gives avg_out=10 (stale buffer data is not subtracted).

Source files
------------

// File: rtl/audio_window_averager.sv
// rtl/audio_window_averager.sv - decimated block or moving average of a mic sample stream
// One sample per DECIM clocks; emits a window average plus a threshold flag.
module audio_window_averager #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 5,
  parameter int DECIM  = 10,
  parameter int MODE   = 0
) (
  input  logic              Clk_20khz,
  input  logic              Rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] mic_in,
  input  logic [DATA_W-1:0] thresh,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              over_thresh
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DEC_W-1:0]  dec_q, dec_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [LOG2_N-1:0] wp_q, wp_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              valid_q, valid_d;
  logic              over_q, over_d;

  logic [DATA_W-1:0] ring_q [N];
  logic              ring_we;
  logic              tick;
  logic [ACC_W-1:0]  blk_sum, mov_sum, new_sum;
  logic [DATA_W-1:0] new_avg;

  assign tick = (dec_q == DEC_W'(DECIM - 1));

  // acc doubles as the running boxcar sum in moving mode; subtracting the
  // evicted sample first keeps the intermediate inside ACC_W bits.
  assign blk_sum = acc_q + ACC_W'(mic_in);
  assign mov_sum = (acc_q - (full_q ? ACC_W'(ring_q[wp_q]) : '0)) + ACC_W'(mic_in);
  assign new_sum = (MODE == 0) ? blk_sum : mov_sum;
  assign new_avg = new_sum[ACC_W-1:LOG2_N];
  assign ring_we = (MODE != 0) && tick && !clr;

  always_comb begin
    dec_d   = tick ? '0 : dec_q + DEC_W'(1);
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    full_d  = full_q;
    avg_d   = avg_q;
    valid_d = 1'b0;
    over_d  = over_q;
    if (clr) begin
      dec_d  = '0;
      acc_d  = '0;
      cnt_d  = '0;
      wp_d   = '0;
      full_d = 1'b0;
    end else if (tick) begin
      if (MODE == 0) begin
        if (cnt_q == LOG2_N'(N - 1)) begin
          acc_d   = '0;
          cnt_d   = '0;
          avg_d   = new_avg;
          over_d  = (new_avg >= thresh);
          valid_d = 1'b1;
        end else begin
          acc_d = blk_sum;
          cnt_d = cnt_q + LOG2_N'(1);
        end
      end else begin
        acc_d = mov_sum;
        wp_d  = wp_q + LOG2_N'(1);
        if (wp_q == LOG2_N'(N - 1)) full_d = 1'b1;
        if (full_d) begin
          avg_d   = new_avg;
          over_d  = (new_avg >= thresh);
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk_20khz or posedge Rst) begin
    if (Rst) begin
      dec_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      full_q  <= 1'b0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      full_q  <= full_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
      over_q  <= over_d;
    end
  end

  // Stale entries are harmless: they are only read once full is set again.
  always_ff @(posedge Clk_20khz) begin
    if (ring_we) ring_q[wp_q] <= mic_in;
  end

  assign avg_out     = avg_q;
  assign avg_valid   = valid_q;
  assign over_thresh = over_q;

endmodule

// File: tb/tb_audio_window_averager.sv
// tb/tb_audio_window_averager.sv - self-checking bench for audio_window_averager
// Block and moving instances share stimulus; a queue model checks every cycle.
`timescale 1ns/1ps
module tb_audio_window_averager;

  localparam int DW = 12;
  localparam int L  = 3;
  localparam int NW = 8;
  localparam int D  = 10;

  logic          clk = 1'b0;
  logic          Rst = 1'b1;
  logic          clr = 1'b0;
  logic [DW-1:0] mic_in = '0;
  logic [DW-1:0] thresh = '0;
  logic [DW-1:0] avg_b, avg_m;
  logic          vld_b, vld_m, ovr_b, ovr_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  audio_window_averager #(.DATA_W(DW), .LOG2_N(L), .DECIM(D), .MODE(0)) u_blk (
    .Clk_20khz(clk), .Rst(Rst), .clr(clr), .mic_in(mic_in), .thresh(thresh),
    .avg_out(avg_b), .avg_valid(vld_b), .over_thresh(ovr_b));

  audio_window_averager #(.DATA_W(DW), .LOG2_N(L), .DECIM(D), .MODE(1)) u_mov (
    .Clk_20khz(clk), .Rst(Rst), .clr(clr), .mic_in(mic_in), .thresh(thresh),
    .avg_out(avg_m), .avg_valid(vld_m), .over_thresh(ovr_m));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: count edges since restart, collect samples, average with plain division.
  int m_edges;
  int q_b[$];
  int q_m[$];
  int e_avg_b, e_avg_m;
  bit e_vld_b, e_vld_m, e_ovr_b, e_ovr_m;

  always @(posedge clk or posedge Rst) begin
    if (Rst) begin
      m_edges = 0;
      q_b.delete();
      q_m.delete();
      e_avg_b = 0; e_vld_b = 0; e_ovr_b = 0;
      e_avg_m = 0; e_vld_m = 0; e_ovr_m = 0;
    end else begin
      e_vld_b = 0;
      e_vld_m = 0;
      if (clr) begin
        m_edges = 0;
        q_b.delete();
        q_m.delete();
      end else begin
        m_edges++;
        if (m_edges == D) begin
          m_edges = 0;
          q_b.push_back(int'(mic_in));
          q_m.push_back(int'(mic_in));
          if (q_m.size() > NW) void'(q_m.pop_front());
          if (q_b.size() == NW) begin
            int s;
            s = 0;
            foreach (q_b[i]) s += q_b[i];
            e_avg_b = s / NW;
            e_ovr_b = (e_avg_b >= int'(thresh));
            e_vld_b = 1;
            q_b.delete();
          end
          if (q_m.size() == NW) begin
            int s;
            s = 0;
            foreach (q_m[i]) s += q_m[i];
            e_avg_m = s / NW;
            e_ovr_m = (e_avg_m >= int'(thresh));
            e_vld_m = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_avg_blk", avg_b, e_avg_b);
    chk("cyc_vld_blk", vld_b, e_vld_b);
    chk("cyc_ovr_blk", ovr_b, e_ovr_b);
    chk("cyc_avg_mov", avg_m, e_avg_m);
    chk("cyc_vld_mov", vld_m, e_vld_m);
    chk("cyc_ovr_mov", ovr_m, e_ovr_m);
  end

  task automatic check_zero(input string tag);
    chk({tag, "_avg_blk"}, avg_b, 0);
    chk({tag, "_vld_blk"}, vld_b, 0);
    chk({tag, "_ovr_blk"}, ovr_b, 0);
    chk({tag, "_avg_mov"}, avg_m, 0);
    chk({tag, "_vld_mov"}, vld_m, 0);
    chk({tag, "_ovr_mov"}, ovr_m, 0);
  endtask

  // Leaves the bench 1 ns after a rising edge with Rst just released.
  task automatic do_reset();
    @(posedge clk);
    #3 Rst = 1'b1;
    #1 check_zero("rst");
    @(posedge clk);
    @(posedge clk);
    #1 Rst = 1'b0;
  endtask

  // Present one sample for a full decimation period; returns 1 ns after its tick edge.
  task automatic tick_sample(input int v);
    mic_in = DW'(v);
    repeat (D) @(posedge clk);
    #1;
  endtask

  initial begin
    // constant 100: block updates on edges 80 and 160
    #2 do_reset();
    mic_in = 100;
    repeat (79) @(posedge clk);
    #1 chk("t1_e79_vld_blk", vld_b, 0);
    @(posedge clk);
    #1 chk("t1_e80_vld_blk", vld_b, 1);
    chk("t1_e80_avg_blk", avg_b, 100);
    chk("t1_e80_vld_mov", vld_m, 1);
    chk("t1_e80_avg_mov", avg_m, 100);
    @(posedge clk);
    #1 chk("t1_e81_vld_blk", vld_b, 0);
    repeat (78) @(posedge clk);
    #1 chk("t1_e159_vld_blk", vld_b, 0);
    @(posedge clk);
    #1 chk("t1_e160_vld_blk", vld_b, 1);
    chk("t1_e160_avg_blk", avg_b, 100);

    // ramp 0..7 then full-scale samples
    do_reset();
    for (int i = 0; i < NW; i++) tick_sample(i);
    chk("t2_ramp_vld_blk", vld_b, 1);
    chk("t2_ramp_avg_blk", avg_b, 3);
    chk("t2_ramp_avg_mov", avg_m, 3);
    for (int i = 0; i < NW; i++) tick_sample(4095);
    chk("t2_max_avg_blk", avg_b, 4095);
    chk("t2_max_avg_mov", avg_m, 4095);

    // moving average decays after a step to zero
    do_reset();
    for (int i = 0; i < NW; i++) tick_sample(800);
    chk("t3_fill_avg_mov", avg_m, 800);
    for (int k = 1; k <= NW; k++) begin
      tick_sample(0);
      chk($sformatf("t3_decay%0d_vld_mov", k), vld_m, 1);
      chk($sformatf("t3_decay%0d_avg_mov", k), avg_m, 800 - 100 * k);
    end

    // clr coincident with the 4th tick
    do_reset();
    for (int i = 0; i < NW; i++) tick_sample(40);
    chk("t4_pre_avg_blk", avg_b, 40);
    for (int i = 0; i < 3; i++) tick_sample(50);
    mic_in = 999;
    repeat (D - 1) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("t4_clr_vld_blk", vld_b, 0);
    chk("t4_clr_avg_blk", avg_b, 40);
    chk("t4_clr_vld_mov", vld_m, 0);
    chk("t4_clr_avg_mov", avg_m, 43);
    for (int i = 0; i < NW - 1; i++) tick_sample(20);
    chk("t4_7th_vld_blk", vld_b, 0);
    tick_sample(20);
    chk("t4_8th_vld_blk", vld_b, 1);
    chk("t4_8th_avg_blk", avg_b, 20);
    chk("t4_8th_avg_mov", avg_m, 20);

    // threshold at 499 vs 500; mid-window thresh change has no effect
    do_reset();
    thresh = 500;
    for (int i = 0; i < NW; i++) tick_sample((i % 2) ? 508 : 490);
    chk("t5_w1_avg_blk", avg_b, 499);
    chk("t5_w1_ovr_blk", ovr_b, 0);
    mic_in = 500;
    thresh = 100;
    repeat (5) @(posedge clk);
    #1 chk("t5_hold_ovr_blk", ovr_b, 0);
    thresh = 500;
    repeat (D - 5) @(posedge clk);
    #1;
    for (int i = 0; i < NW - 1; i++) tick_sample(500);
    chk("t5_w2_avg_blk", avg_b, 500);
    chk("t5_w2_ovr_blk", ovr_b, 1);

    // reset mid-window after a full-scale fill; stale ring data must be ignored
    do_reset();
    for (int i = 0; i < NW + 3; i++) tick_sample(4095);
    chk("t6_pre_avg_mov", avg_m, 4095);
    repeat (3) @(posedge clk);
    #3 Rst = 1'b1;
    #1 check_zero("t6_async");
    @(posedge clk);
    @(posedge clk);
    #1 Rst = 1'b0;
    for (int i = 0; i < NW - 1; i++) tick_sample(10);
    chk("t6_7th_vld_mov", vld_m, 0);
    tick_sample(10);
    chk("t6_8th_vld_mov", vld_m, 1);
    chk("t6_8th_avg_mov", avg_m, 10);
    chk("t6_8th_avg_blk", avg_b, 10);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
